// File: rtl/mem_slot_arbiter_if.sv
// Signal bundle between the SDRAM slot arbiter and its requesters / SDRAM controller.
// master = core, loader, DMA and SDRAM side; slave = the arbiter.
interface mem_slot_arbiter_if #(
  parameter int ADDR_W   = 25,
  parameter int STARVE_W = 4
);
  logic              sync;
  logic              phi0;
  logic              vid_blnk;
  logic [ADDR_W-1:0] vid_adr;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [7:0]        cpu_di;

  logic              ld_active;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_adr;
  logic [7:0]        ld_data;
  logic              ld_full;
  logic              ld_overflow;

  // DMA handshake: dma_req is a level held with stable dma_adr/dma_we/dma_di
  // until the one-cycle dma_ack; dropping dma_req before dma_ack cancels it.
  // A read grant is answered by a one-cycle dma_rvalid one slot later.
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_adr;
  logic [7:0]        dma_di;
  logic              dma_ack;
  logic              dma_rvalid;
  logic [7:0]        dma_dout;

  logic [7:0]        sd_do;
  logic [ADDR_W-1:0] sd_adr;
  logic              sd_we;
  logic [7:0]        sd_di;

  logic [1:0]        owner;
  logic              cpu_stall;

  logic [STARVE_W-1:0] starve;
  logic                dma_pending;

  modport master (
    output sync, phi0, vid_blnk, vid_adr,
    output cpu_req, cpu_we, cpu_adr, cpu_di,
    output ld_active, ld_we, ld_adr, ld_data,
    input  ld_full, ld_overflow,
    output dma_req, dma_we, dma_adr, dma_di,
    input  dma_ack, dma_rvalid, dma_dout,
    output sd_do,
    input  sd_adr, sd_we, sd_di,
    input  owner, cpu_stall,
    input  starve, dma_pending
  );

  modport slave (
    input  sync, phi0, vid_blnk, vid_adr,
    input  cpu_req, cpu_we, cpu_adr, cpu_di,
    input  ld_active, ld_we, ld_adr, ld_data,
    output ld_full, ld_overflow,
    input  dma_req, dma_we, dma_adr, dma_di,
    output dma_ack, dma_rvalid, dma_dout,
    input  sd_do,
    output sd_adr, sd_we, sd_di,
    output owner, cpu_stall,
    output starve, dma_pending
  );
endinterface

// File: rtl/mem_slot_arbiter.sv
// Per-slot owner selection for the byte-wide SDRAM port: video, CPU, loader FIFO, DMA.
// Grants are decided on the sync cycle and held as registered outputs for the slot.
module mem_slot_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int FIFO_AW    = 2,
  parameter int STARVE_MAX = 8
) (
  input logic               clk_sys,
  input logic               rst_n,
  mem_slot_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_CPU = 2'd1,
    OWN_LD  = 2'd2,
    OWN_DMA = 2'd3
  } owner_t;

  logic [ADDR_W-1:0]  fifo_adr [DEPTH];
  logic [7:0]         fifo_dat [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic               overflow;

  logic [SW-1:0]      starve;
  logic               rd_pend;

  owner_t             owner;
  logic [ADDR_W-1:0]  sd_adr;
  logic               sd_we;
  logic [7:0]         sd_di;
  logic               cpu_stall;
  logic               dma_ack;
  logic               dma_rvalid;
  logic [7:0]         dma_dout;

  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push;

  owner_t             nxt_owner;
  logic [ADDR_W-1:0]  nxt_adr;
  logic               nxt_we;
  logic [7:0]         nxt_di;
  logic               dma_win;
  logic [SW-1:0]      nxt_starve;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = bus.sync && !fifo_empty;
  // A full FIFO still accepts a strobe when the head leaves on the same edge.
  assign push       = bus.ld_we && (!fifo_full || pop);

  always_comb begin
    nxt_owner = OWN_VID;
    nxt_adr   = bus.vid_adr;
    nxt_we    = 1'b0;
    nxt_di    = '0;
    dma_win   = 1'b0;
    if (!fifo_empty) begin
      nxt_owner = OWN_LD;
      nxt_adr   = fifo_adr[rd_ptr];
      nxt_we    = 1'b1;
      nxt_di    = fifo_dat[rd_ptr];
    end else if (bus.ld_active) begin
      if (bus.phi0) begin
        nxt_owner = OWN_CPU;
        nxt_adr   = bus.cpu_adr;
      end
    end else if (!bus.phi0) begin
      dma_win = bus.vid_blnk && bus.dma_req;
    end else begin
      dma_win = bus.dma_req && (!bus.cpu_req || starve == STARVE_LIM);
      if (!dma_win) begin
        nxt_owner = OWN_CPU;
        nxt_adr   = bus.cpu_adr;
        nxt_we    = bus.cpu_we && bus.cpu_req;
        nxt_di    = bus.cpu_di;
      end
    end
    if (dma_win) begin
      nxt_owner = OWN_DMA;
      nxt_adr   = bus.dma_adr;
      nxt_we    = bus.dma_we;
      nxt_di    = bus.dma_di;
    end
  end

  // Only a normal CPU slot that the CPU actually won counts as a DMA loss.
  always_comb begin
    nxt_starve = starve;
    if (!bus.dma_req || dma_win) begin
      nxt_starve = '0;
    end else if (fifo_empty && !bus.ld_active && bus.phi0 && starve != STARVE_LIM) begin
      nxt_starve = starve + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_adr[wr_ptr] <= bus.ld_adr;
      fifo_dat[wr_ptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      starve     <= '0;
      rd_pend    <= 1'b0;
      owner      <= OWN_VID;
      sd_adr     <= '0;
      sd_we      <= 1'b0;
      sd_di      <= '0;
      cpu_stall  <= 1'b0;
      dma_ack    <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_dout   <= '0;
    end else begin
      dma_ack    <= 1'b0;
      dma_rvalid <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (bus.ld_we && !push) begin
        overflow <= 1'b1;
      end
      if (bus.sync) begin
        owner     <= nxt_owner;
        sd_adr    <= nxt_adr;
        sd_we     <= nxt_we;
        sd_di     <= nxt_di;
        cpu_stall <= bus.phi0 && (nxt_owner != OWN_CPU);
        dma_ack   <= dma_win;
        starve    <= nxt_starve;
        // sd_do at this sync closes the previous slot, so it answers a pending DMA read.
        if (rd_pend) begin
          dma_rvalid <= 1'b1;
          dma_dout   <= bus.sd_do;
        end
        rd_pend <= dma_win && !bus.dma_we;
      end
    end
  end

  assign bus.owner       = owner;
  assign bus.sd_adr      = sd_adr;
  assign bus.sd_we       = sd_we;
  assign bus.sd_di       = sd_di;
  assign bus.cpu_stall   = cpu_stall;
  assign bus.dma_ack     = dma_ack;
  assign bus.dma_rvalid  = dma_rvalid;
  assign bus.dma_dout    = dma_dout;
  assign bus.ld_full     = fifo_full;
  assign bus.ld_overflow = overflow;
  assign bus.starve      = starve;
  assign bus.dma_pending = rd_pend;
endmodule

// File: doc/mem_slot_arbiter.md
# mem_slot_arbiter

Schedules the single byte-wide SDRAM port between video fetch, CPU, the ROM/data loader and a secondary DMA requester (disc/tape helper). It sits between the machine core, `data_io` and the `sdram` controller, and replaces the ad-hoc priority address mux and loader write latch at top level. Slot boundaries come from the core's `mem_sync` pulse; video and CPU phases come from `phi0`. All grants are decided once per slot and held for the whole slot.

## Interface
Parameters:
- ADDR_W, 25, SDRAM byte address width
- FIFO_AW, 2, log2 of loader FIFO depth (depth 4)
- STARVE_MAX, 8, CPU slots a pending DMA may lose before it is forced through

Ports:
- clk_sys  in  1  system clock (32 MHz)
- rst_n  in  1  reset, synchronous, active-low
- sync  in  1  one-cycle pulse marking the start of an SDRAM slot
- phi0  in  1  slot phase, sampled with sync: 0 = video slot, 1 = CPU slot
- vid_blnk  in  1  video blanking, sampled with sync
- vid_adr  in  ADDR_W  video fetch address
- cpu_req, cpu_we  in  1  CPU wants the slot / slot is a write
- cpu_adr  in  ADDR_W; cpu_di  in  8
- ld_active  in  1  loader download in progress
- ld_we  in  1  one-cycle write strobe from loader
- ld_adr  in  ADDR_W; ld_data  in  8
- ld_full  out  1  FIFO holds FIFO depth entries
- ld_overflow  out  1  sticky: a strobe arrived while full
- dma_req, dma_we  in  1; dma_adr  in  ADDR_W; dma_di  in  8
- dma_ack  out  1  one-cycle grant pulse
- dma_rvalid  out  1  one-cycle read-data pulse; dma_dout  out  8
- sd_do  in  8  SDRAM read data, valid at the sync ending a slot
- sd_adr  out  ADDR_W; sd_we  out  1; sd_di  out  8  to sdram controller
- owner  out  2  0 video, 1 CPU, 2 loader, 3 DMA
- cpu_stall  out  1  CPU slot given to another requester

## Operation
- Loader FIFO: ld_we pushes {ld_adr, ld_data} when not full. A push while full is dropped and sets ld_overflow. Push and pop in the same cycle are both honoured; the count is unchanged.
- Loader mode = ld_active OR FIFO non-empty. The FIFO therefore drains after ld_active falls.
- Arbitration happens on each cycle with sync=1. It uses sampled phi0, vid_blnk, the requests and the FIFO state:
  - Loader mode, FIFO non-empty: owner=2, pop head, sd_we=1.
  - Loader mode, FIFO empty: owner = phase default (0 or 1), sd_we=0. Reads are harmless.
  - phi0=0: if vid_blnk and dma_req, owner=3. Else owner=0, address vid_adr, sd_we=0.
  - phi0=1: if dma_req and (!cpu_req or starve==STARVE_MAX), owner=3. Else owner=1, with sd_we=cpu_we and cpu_req.
- Starve counter (width clog2(STARVE_MAX+1)):
  - Cleared on a DMA grant or when dma_req=0.
  - Incremented on each CPU slot where dma_req=1 and the CPU won.
  - Saturates at STARVE_MAX.
- cpu_stall=1 for a phi0=1 slot whose owner is not 1.
- DMA grant:
  - dma_ack pulses once and sd_we=dma_we.
  - For a read grant, dma_dout captures sd_do at the next sync and dma_rvalid pulses.
  - The requester must hold dma_adr, dma_we and dma_di stable while dma_req=1 until dma_ack.
  - dma_req is re-sampled each slot. A drop before the grant cancels the request.

## Timing
- Registered outputs. On the clk_sys edge where sync=1, owner, sd_adr, sd_we, sd_di, cpu_stall and dma_ack update. They are visible the following cycle and held until the next sync edge.
- dma_ack is high for exactly that one cycle.
- dma_rvalid/dma_dout update on the edge of the next sync after a DMA read grant: one slot of latency.
- ld_full and ld_overflow update on the edge after the push/pop.
- Loader strobe to SDRAM write: at most the first sync after the entry reaches the FIFO head.
- Reset (rst_n=0 on any edge, including mid-slot):
  - Next state: owner=0, sd_adr=0, sd_we=0, sd_di=0, cpu_stall=0, dma_ack=0, dma_rvalid=0, dma_dout=0.
  - FIFO empty, ld_full=0, ld_overflow=0, starve=0.
  - Any pending DMA read is discarded, so no rvalid follows.
- sync while rst_n=0 is ignored.

## Test plan
- Reset mid-DMA-read: grant a DMA read, assert rst_n=0 before the next sync. Require all outputs 0 and no dma_rvalid afterwards.
- Alternating slots, no loader or DMA: video slot gives owner=0, sd_adr=vid_adr, sd_we=0. CPU write slot with cpu_adr=0x0123, cpu_di=0x5A gives owner=1, sd_we=1, sd_di=0x5A, cpu_stall=0.
- Loader burst: 5 ld_we strobes back to back with no sync.
  - Entries 1–4 are accepted, ld_full=1 after the 4th.
  - The 5th sets ld_overflow.
  - Next 4 syncs give owner=2, sd_we=1 with addresses in order, even after ld_active drops; then normal arbitration resumes.
- Simultaneous push/pop: with 4 entries, strobe ld_we on the sync cycle. Require the pop to occur, the push to be accepted, and ld_full=1 with no overflow.
- DMA starvation: dma_req=1 and cpu_req=1 held, vid_blnk=0. Require CPU to win 8 CPU slots, DMA to win the 9th (dma_ack, cpu_stall=1), and the counter to clear.
- DMA in blanking: vid_blnk=1, phi0=0, DMA read of 0x80000 gives owner=3. With sd_do=0xC3 at the next sync, require dma_rvalid pulse and dma_dout=0xC3.
